// File: rtl/set_ctrl_if.sv
// Handshake bundle between the time-setting controller and the clock datapath / key front end.
// master drives ticks and keys, slave (set_ctrl) drives the registered control outputs.
interface set_ctrl_if;
    logic       tick_1khz;
    logic       key_mode;
    logic       key_up;
    logic       run_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic [3:0] blank;
    logic [1:0] state;

    modport master (
        output tick_1khz, key_mode, key_up,
        input  run_en, inc_hour, inc_min, clr_sec, blank, state
    );

    modport slave (
        input  tick_1khz, key_mode, key_up,
        output run_en, inc_hour, inc_min, clr_sec, blank, state
    );
endinterface

// File: rtl/set_ctrl.sv
// Clock time-set controller: key sync/edge detect, RUN/SET_H/SET_M/SET_S FSM, auto-repeat, idle timeout, blink.
// Key-to-pulse latency is 3 cycles from the first sampling edge; all outputs registered, no backpressure.
module set_ctrl #(
    parameter int TIMEOUT_MS = 10000,
    parameter int HOLD_MS    = 800,
    parameter int REPEAT_MS  = 200,
    parameter int BLINK_MS   = 250
) (
    input  logic        CLK_50,
    input  logic        CR,
    set_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } state_t;

    localparam int HR_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int IW     = $clog2(TIMEOUT_MS + 1);
    localparam int HW     = $clog2(HR_MAX + 1);
    localparam int BW     = $clog2(BLINK_MS + 1);

    // key front end
    logic       mode_s1, mode_s2, mode_prev, mode_edge;
    logic       up_s1, up_s2, up_prev, up_edge;
    logic [1:0] prime_cnt;
    logic       primed;

    // Edges are suppressed until the sync pipeline has refilled, so a key held through reset never fires.
    assign primed = (prime_cnt == 2'd3);

    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            mode_s1   <= 1'b0;
            mode_s2   <= 1'b0;
            mode_prev <= 1'b0;
            mode_edge <= 1'b0;
            up_s1     <= 1'b0;
            up_s2     <= 1'b0;
            up_prev   <= 1'b0;
            up_edge   <= 1'b0;
            prime_cnt <= 2'd0;
        end else begin
            mode_s1   <= bus.key_mode;
            mode_s2   <= mode_s1;
            mode_prev <= mode_s2;
            mode_edge <= primed & mode_s2 & ~mode_prev;
            up_s1     <= bus.key_up;
            up_s2     <= up_s1;
            up_prev   <= up_s2;
            up_edge   <= primed & up_s2 & ~up_prev;
            if (!primed) prime_cnt <= prime_cnt + 2'd1;
        end
    end

    // control state
    state_t         state_q, state_d;
    logic [IW-1:0]  idle_cnt, idle_d;
    logic [HW-1:0]  hold_cnt, hold_d;
    logic [BW-1:0]  blink_cnt, blink_d;
    logic           repeating, rpt_d;
    logic           rep_armed, arm_d;
    logic           phase, phase_d;
    logic           inc_h_d, inc_m_d, clr_d;
    logic [3:0]     blank_d;
    logic           rep_pulse, timeout, tick;

    logic           run_en_q, inc_hour_q, inc_min_q, clr_sec_q;
    logic [3:0]     blank_q;

    assign tick = bus.tick_1khz;

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_cnt;
        hold_d    = hold_cnt;
        rpt_d     = repeating;
        arm_d     = rep_armed;
        blink_d   = blink_cnt;
        phase_d   = phase;
        inc_h_d   = 1'b0;
        inc_m_d   = 1'b0;
        clr_d     = 1'b0;
        rep_pulse = 1'b0;
        timeout   = 1'b0;
        blank_d   = 4'b0000;

        // Hold/repeat engine: first target HOLD_MS, then REPEAT_MS, restarting on each repeat pulse.
        if (!up_s2) begin
            arm_d  = 1'b0;
            hold_d = '0;
            rpt_d  = 1'b0;
        end else if (rep_armed && tick) begin
            if (int'(hold_cnt) + 1 == (repeating ? REPEAT_MS : HOLD_MS)) begin
                rep_pulse = 1'b1;
                hold_d    = '0;
                rpt_d     = 1'b1;
            end else begin
                hold_d = hold_cnt + HW'(1);
            end
        end

        if (state_q != RUN && tick) begin
            if (int'(idle_cnt) + 1 == TIMEOUT_MS) begin
                timeout = 1'b1;
                idle_d  = '0;
            end else begin
                idle_d = idle_cnt + IW'(1);
            end
        end

        // Priority: mode edge, then up edge, then repeat pulse, then idle timeout.
        if (mode_edge) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                default: state_d = RUN;
            endcase
            arm_d     = 1'b0;
            hold_d    = '0;
            rpt_d     = 1'b0;
            rep_pulse = 1'b0;
        end else if (up_edge) begin
            case (state_q)
                SET_H: begin
                    inc_h_d = 1'b1;
                    arm_d   = 1'b1;
                end
                SET_M: begin
                    inc_m_d = 1'b1;
                    arm_d   = 1'b1;
                end
                SET_S:   clr_d = 1'b1;
                default: arm_d = 1'b0;
            endcase
            hold_d    = '0;
            rpt_d     = 1'b0;
            rep_pulse = 1'b0;
        end else if (rep_pulse) begin
            if (state_q == SET_H) inc_h_d = 1'b1;
            if (state_q == SET_M) inc_m_d = 1'b1;
        end else if (timeout) begin
            state_d = RUN;
            arm_d   = 1'b0;
            hold_d  = '0;
            rpt_d   = 1'b0;
        end

        if (mode_edge || up_edge || rep_pulse || state_d == RUN) idle_d = '0;

        if (tick) begin
            if (int'(blink_cnt) + 1 == BLINK_MS) begin
                phase_d = ~phase;
                blink_d = '0;
            end else begin
                blink_d = blink_cnt + BW'(1);
            end
        end
        // Any visible change snaps the digits on so the user sees the result at once.
        if (state_d != state_q || inc_h_d || inc_m_d || clr_d) begin
            phase_d = 1'b0;
            blink_d = '0;
        end

        case (state_d)
            SET_H:   blank_d = {phase_d, phase_d, 2'b00};
            SET_M:   blank_d = {2'b00, phase_d, phase_d};
            SET_S:   blank_d = {4{phase_d}};
            default: blank_d = 4'b0000;
        endcase
    end

    always_ff @(posedge CLK_50 or posedge CR) begin
        if (CR) begin
            state_q    <= RUN;
            idle_cnt   <= '0;
            hold_cnt   <= '0;
            blink_cnt  <= '0;
            repeating  <= 1'b0;
            rep_armed  <= 1'b0;
            phase      <= 1'b0;
            run_en_q   <= 1'b1;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            clr_sec_q  <= 1'b0;
            blank_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            idle_cnt   <= idle_d;
            hold_cnt   <= hold_d;
            blink_cnt  <= blink_d;
            repeating  <= rpt_d;
            rep_armed  <= arm_d;
            phase      <= phase_d;
            run_en_q   <= (state_d == RUN);
            inc_hour_q <= inc_h_d;
            inc_min_q  <= inc_m_d;
            clr_sec_q  <= clr_d;
            blank_q    <= blank_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.run_en   = run_en_q;
    assign bus.inc_hour = inc_hour_q;
    assign bus.inc_min  = inc_min_q;
    assign bus.clr_sec  = clr_sec_q;
    assign bus.blank    = blank_q;

endmodule

// File: doc/set_ctrl.md
SET_CTRL -- requirements
Module: set_ctrl

Interface
REQ-001 Parameter TIMEOUT_MS, default 10000: number of idle 1 kHz ticks before a set state auto-returns to RUN.
REQ-002 Parameter HOLD_MS, default 800: number of 1 kHz ticks key_up must stay held before auto-repeat starts.
REQ-003 Parameter REPEAT_MS, default 200: number of 1 kHz ticks between auto-repeat pulses.
REQ-004 Parameter BLINK_MS, default 250: number of 1 kHz ticks per blink half-period.
REQ-005 CLK_50  in  1  system clock; all logic on its rising edge.
REQ-006 CR  in  1  reset, asynchronous, active-high; clears all state.
REQ-007 tick_1khz  in  1  one-CLK_50-cycle strobe at 1 kHz; all timers count only on this strobe.
REQ-008 key_mode  in  1  debounced mode key, level, active-high, asynchronous to CLK_50.
REQ-009 key_up  in  1  debounced increment key, level, active-high, asynchronous to CLK_50.
REQ-010 run_en  out  1  enable for the seconds counter chain.
REQ-011 inc_hour  out  1  one-cycle pulse: advance hour counter by one.
REQ-012 inc_min  out  1  one-cycle pulse: advance minute counter by one.
REQ-013 clr_sec  out  1  one-cycle pulse: clear the seconds counter.
REQ-014 blank  out  4  per-digit blanking mask; [3:2] hour digits, [1:0] minute digits; 1 = digit dark.
REQ-015 state  out  2  current state encoding: RUN=00, SET_H=01, SET_M=10, SET_S=11.

Function
REQ-016 key_mode and key_up shall each pass through a 2-flop synchronizer followed by a registered rising-edge detector.
REQ-017 An output pulse caused by a key edge shall assert exactly 3 CLK_50 cycles after the raw key rises, counted from the first sampling edge.
REQ-018 A mode edge shall advance the state RUN->SET_H->SET_M->SET_S->RUN.
REQ-019 run_en shall be 1 in RUN and 0 in every set state.
REQ-020 In SET_H, a key_up edge shall produce one inc_hour pulse.
REQ-021 In SET_M, a key_up edge shall produce one inc_min pulse.
REQ-022 In SET_S, a key_up edge shall produce one clr_sec pulse.
REQ-023 In RUN, key_up shall be ignored and shall produce no pulses.
REQ-024 Auto-repeat: in SET_H or SET_M, once key_up has been held HOLD_MS ticks after its edge, one further pulse shall issue, followed by one every REPEAT_MS ticks while held.
REQ-025 Auto-repeat shall not occur in SET_S.
REQ-026 Releasing key_up shall stop repeat immediately and clear the hold/repeat counter.
REQ-027 Idle timer: in a set state, a timer shall count ticks and restart to 0 on any key edge and on every repeat pulse.
REQ-028 When the idle timer reaches TIMEOUT_MS, the state shall go to RUN on that tick with no pulse issued.
REQ-029 Blink: a phase bit shall toggle every BLINK_MS ticks; it shall be forced to 0 (visible) on every state change and every inc/clr pulse, and the blink counter shall restart at the same time.
REQ-030 blank shall equal {phase,phase,0,0} in SET_H, {0,0,phase,phase} in SET_M, {phase,phase,phase,phase} in SET_S, and 4'b0000 in RUN.
REQ-031 Mode and up edges in the same cycle: mode wins; the state advances, no inc/clr pulse issues, and the repeat counter clears.
REQ-032 A mode edge while key_up is held shall cancel repeat; the held key shall not act in the new state until released and pressed again.
REQ-033 Timeout and a key edge on the same cycle: the key edge wins and the timer restarts.
REQ-034 All outputs shall be registered, with at most one of inc_hour, inc_min, clr_sec high in any cycle.
REQ-035 All counters shall be wide enough for their parameter and shall saturate or restart, never wrap silently.

Reset
REQ-036 While CR=1, the block shall hold state=RUN, run_en=1, inc_hour=inc_min=clr_sec=0, blank=0000, and all synchronizers, timers and the phase bit at 0.
REQ-037 Asserting CR mid-set or mid-repeat shall abort immediately to RUN with no pulse.
REQ-038 After CR falls, a key already held high shall not generate an edge.

Verification
REQ-039 Reset, then 3 mode presses -> state 01, 10, 11; run_en goes 1->0 after the first press; 4th press -> state 00, run_en=1.
REQ-040 SET_H, with key_up rising at cycle t -> inc_hour=1 only at cycle t+3; held 1000 ticks with defaults -> 1 edge pulse plus repeats at ticks 800 and 1000, for 3 pulses total.
REQ-041 SET_M, idle 10000 ticks -> state=00 at tick 10000; a key edge at tick 9999 -> state stays 10.
REQ-042 SET_H blink -> blank toggles 0000/1100 every 250 ticks; an inc_hour pulse forces 0000.
REQ-043 Simultaneous mode and up edge in SET_M -> state=11 with no inc_min and no clr_sec.
REQ-044 CR pulse during auto-repeat in SET_M -> next cycle state=00, all pulses 0, blank=0000.
